// File: rtl/buzzer_decoder.sv
// Recovers buzzer on/off state and a 3-bit tone code from the raw buzzer square wave,
// measuring half-periods in 32768 Hz ticks and locking after two matching half-periods.
module buzzer_decoder #(
    parameter int unsigned TIMEOUT_TICKS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       buzzer_in,
    output logic       tone_active,
    output logic [2:0] tone_frequency,
    output logic       tone_update
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);

    logic [1:0] state;
    logic       sample;
    logic [7:0] cnt;
    logic       cand_valid;
    logic [2:0] cand;

    logic       edge_tick;
    logic [8:0] half;
    logic       h_valid;
    logic [2:0] h_code;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        edge_tick = clk_en && (buzzer_in != sample);
        half      = {1'b0, cnt} + 9'd1;
        h_valid   = 1'b1;
        h_code    = 3'd0;
        case (half)
            9'd4:    h_code = 3'd0;
            9'd5:    h_code = 3'd1;
            9'd6:    h_code = 3'd2;
            9'd7:    h_code = 3'd3;
            9'd8:    h_code = 3'd4;
            9'd10:   h_code = 3'd5;
            9'd12:   h_code = 3'd6;
            9'd14:   h_code = 3'd7;
            default: h_valid = 1'b0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            sample         <= 1'b0;
            cnt            <= 8'd0;
            cand_valid     <= 1'b0;
            cand           <= 3'd0;
            tone_frequency <= 3'd0;
            tone_update    <= 1'b0;
        end else begin
            tone_update <= 1'b0;
            if (clk_en) begin
                sample <= buzzer_in;
                if (edge_tick)
                    cnt <= 8'd0;
                else if (cnt != 8'hFF)
                    cnt <= cnt + 8'd1;

                case (state)
                    S_IDLE: begin
                        if (edge_tick) begin
                            state      <= S_MEASURE;
                            cand_valid <= 1'b0;
                        end
                    end
                    S_MEASURE: begin
                        if (edge_tick) begin
                            if (h_valid && cand_valid && h_code == cand) begin
                                state          <= S_LOCKED;
                                tone_frequency <= h_code;
                                tone_update    <= 1'b1;
                            end else if (h_valid) begin
                                cand       <= h_code;
                                cand_valid <= 1'b1;
                            end else begin
                                cand_valid <= 1'b0;
                            end
                        end else if (cnt == TIMEOUT_LAST) begin
                            state <= S_IDLE;
                        end
                    end
                    S_LOCKED: begin
                        // A matching half-period keeps the lock silently.
                        if (edge_tick) begin
                            if (!(h_valid && h_code == tone_frequency)) begin
                                state      <= S_MEASURE;
                                cand       <= h_code;
                                cand_valid <= h_valid;
                            end
                        end else if (cnt == TIMEOUT_LAST) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign tone_active = (state == S_LOCKED);

endmodule

// File: tb/tb_buzzer_decoder.sv
// Directed bench for buzzer_decoder: reset, locking, code sweep, frequency change,
// timeout, non-lockable half-period, tick gating and asynchronous reset.
module tb_buzzer_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_en = 1'b0;
    logic       buzzer_in = 1'b0;
    logic       tone_active;
    logic [2:0] tone_frequency;
    logic       tone_update;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int stray_upd = 0;
    logic lvl = 1'b0;

    buzzer_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .buzzer_in      (buzzer_in),
        .tone_active    (tone_active),
        .tone_frequency (tone_frequency),
        .tone_update    (tone_update)
    );

    always #5 clk = ~clk;

    // One tick cycle followed by one idle cycle; tone_update is sampled on both.
    task automatic tick(input logic b);
        buzzer_in = b;
        clk_en = 1'b1;
        @(posedge clk); #1;
        if (tone_update === 1'b1) upd_cnt++;
        clk_en = 1'b0;
        @(posedge clk); #1;
        if (tone_update !== 1'b0) stray_upd++;
    endtask

    task automatic half(input int h);
        repeat (h - 1) tick(lvl);
        lvl = ~lvl;
        tick(lvl);
    endtask

    task automatic quiet(input int n);
        repeat (n) tick(lvl);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lvl = ~lvl;
            tick(lvl);
        end
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd0 || tone_update !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: active=%b freq=%0d upd=%b, want 0 0 0", tone_active, tone_frequency, tone_update);
        end
        lvl = 1'b0;
        buzzer_in = 1'b0;
        #3 reset = 1'b1;
        quiet(20);
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd0 || upd_cnt !== 0) begin
            bad++;
            $display("FAIL reset_idle: active=%b freq=%0d upds=%0d, want 0 0 0", tone_active, tone_frequency, upd_cnt);
        end
    endtask

    task automatic test_steady_lock;
        int u0;
        u0 = upd_cnt;
        half(4);
        half(4);
        total++;
        if (tone_active !== 1'b0) begin
            bad++;
            $display("FAIL steady_second_edge: active=%b want 0", tone_active);
        end
        half(4);
        total++;
        if (tone_active !== 1'b1 || tone_frequency !== 3'd0) begin
            bad++;
            $display("FAIL steady_third_edge: active=%b freq=%0d want 1 0", tone_active, tone_frequency);
        end
        repeat (22) half(4);
        total++;
        if (tone_active !== 1'b1 || upd_cnt - u0 !== 1) begin
            bad++;
            $display("FAIL steady_100_ticks: active=%b pulses=%0d want 1 1", tone_active, upd_cnt - u0);
        end
        quiet(14);
        total++;
        if (tone_active !== 1'b1) begin
            bad++;
            $display("FAIL steady_quiet14: active=%b want 1", tone_active);
        end
        quiet(1);
        total++;
        if (tone_active !== 1'b0) begin
            bad++;
            $display("FAIL steady_quiet15: active=%b want 0", tone_active);
        end
        quiet(15);
    endtask

    task automatic test_sweep;
        int hp [8] = '{4, 5, 6, 7, 8, 10, 12, 14};
        int u0;
        for (int c = 0; c < 8; c++) begin
            u0 = upd_cnt;
            half(hp[c]);
            half(hp[c]);
            total++;
            if (tone_active !== 1'b0) begin
                bad++;
                $display("FAIL sweep_pre_lock code=%0d: active=%b want 0", c, tone_active);
            end
            half(hp[c]);
            total++;
            if (tone_active !== 1'b1 || tone_frequency !== 3'(c) || upd_cnt - u0 !== 1) begin
                bad++;
                $display("FAIL sweep_lock code=%0d: active=%b freq=%0d pulses=%0d want 1 %0d 1",
                         c, tone_active, tone_frequency, upd_cnt - u0, c);
            end
            quiet(15);
            total++;
            if (tone_active !== 1'b0) begin
                bad++;
                $display("FAIL sweep_gap code=%0d: active=%b want 0", c, tone_active);
            end
            quiet(15);
        end
    endtask

    task automatic test_freq_change;
        int u0;
        repeat (3) half(6);
        total++;
        if (tone_active !== 1'b1 || tone_frequency !== 3'd2) begin
            bad++;
            $display("FAIL change_lock6: active=%b freq=%0d want 1 2", tone_active, tone_frequency);
        end
        u0 = upd_cnt;
        half(10);
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd2) begin
            bad++;
            $display("FAIL change_drop: active=%b freq=%0d want 0 2", tone_active, tone_frequency);
        end
        half(10);
        total++;
        if (tone_active !== 1'b1 || tone_frequency !== 3'd5 || upd_cnt - u0 !== 1) begin
            bad++;
            $display("FAIL change_relock: active=%b freq=%0d pulses=%0d want 1 5 1",
                     tone_active, tone_frequency, upd_cnt - u0);
        end
        quiet(30);
    endtask

    task automatic test_timeout;
        int u0;
        repeat (3) half(14);
        quiet(14);
        total++;
        if (tone_active !== 1'b1 || tone_frequency !== 3'd7) begin
            bad++;
            $display("FAIL timeout_14: active=%b freq=%0d want 1 7", tone_active, tone_frequency);
        end
        quiet(1);
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd7) begin
            bad++;
            $display("FAIL timeout_15: active=%b freq=%0d want 0 7", tone_active, tone_frequency);
        end
        quiet(16);
        repeat (3) half(14);
        u0 = upd_cnt;
        half(15);
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd7) begin
            bad++;
            $display("FAIL edge_at_limit: active=%b freq=%0d want 0 7", tone_active, tone_frequency);
        end
        repeat (3) half(15);
        total++;
        if (tone_active !== 1'b0 || upd_cnt - u0 !== 0) begin
            bad++;
            $display("FAIL h15_no_lock: active=%b pulses=%0d want 0 0", tone_active, upd_cnt - u0);
        end
        quiet(30);
    endtask

    task automatic test_no_lock_h9;
        int u0;
        u0 = upd_cnt;
        repeat (6) half(9);
        total++;
        if (tone_active !== 1'b0 || upd_cnt - u0 !== 0) begin
            bad++;
            $display("FAIL h9_no_lock: active=%b pulses=%0d want 0 0", tone_active, upd_cnt - u0);
        end
        quiet(30);
    endtask

    task automatic test_gate_and_async_reset;
        repeat (3) half(8);
        total++;
        if (tone_active !== 1'b1 || tone_frequency !== 3'd4) begin
            bad++;
            $display("FAIL gate_lock8: active=%b freq=%0d want 1 4", tone_active, tone_frequency);
        end
        clk_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            buzzer_in = ~buzzer_in;
            @(posedge clk); #1;
            if (tone_update !== 1'b0) stray_upd++;
        end
        buzzer_in = lvl;
        total++;
        if (tone_active !== 1'b1 || tone_frequency !== 3'd4) begin
            bad++;
            $display("FAIL gate_no_ticks: active=%b freq=%0d want 1 4", tone_active, tone_frequency);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd0 || tone_update !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: active=%b freq=%0d upd=%b want 0 0 0", tone_active, tone_frequency, tone_update);
        end
        lvl = 1'b0;
        buzzer_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        quiet(5);
        total++;
        if (tone_active !== 1'b0 || tone_frequency !== 3'd0) begin
            bad++;
            $display("FAIL after_reset: active=%b freq=%0d want 0 0", tone_active, tone_frequency);
        end
    endtask

    initial begin
        test_reset;
        test_steady_lock;
        test_sweep;
        test_freq_change;
        test_timeout;
        test_no_lock_h9;
        test_gate_and_async_reset;
        total++;
        if (stray_upd !== 0) begin
            bad++;
            $display("FAIL update_off_tick: pulses=%0d want 0", stray_upd);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buzzer_decoder.md
# buzzer_decoder

Recovers the piezo buzzer's on/off state and 3-bit frequency select from the raw square wave driven onto the buzzer pin. It sits on the output side of the core's tone generator and feeds the audio/host layer, which needs a stable tone code rather than a toggling bit. The input is sampled on the core's 32768 Hz `clk_en` tick. Half-periods are measured in ticks and a frequency code is reported only after two consecutive matching half-periods.

## Interface
- `TIMEOUT_TICKS`, default 15: number of ticks with no edge before the tone is declared stopped. Legal range is 15..255.

- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset. Asserted when 0.
- `clk_en` input 1: one-`clk` 32768 Hz tick. All state advances only on `clk` edges where `clk_en` = 1.
- `buzzer_in` input 1: buzzer square wave, synchronous to `clk`.
- `tone_active` output 1: high while locked to a valid tone.
- `tone_frequency` output 3: last locked frequency code, 0..7.
- `tone_update` output 1: one-`clk` pulse on each entry into the LOCKED state.

## Operation
- **Edge detection:** `sample` <= `buzzer_in` on each tick. An edge tick is a tick where `buzzer_in` != `sample`.
- **Counter `cnt`:** 8-bit, saturating at 255.
  - On an edge tick, `cnt` <= 0.
  - On a non-edge tick, `cnt` <= `cnt` + 1.
- **Half-period:** on an edge tick, H = `cnt` + 1.
- **Valid H to code mapping:** 4→0, 5→1, 6→2, 7→3, 8→4, 10→5, 12→6, 14→7. Any other H is invalid.
- **Candidate register:** holds a code plus a `cand_valid` bit.
- **States:**
  - **IDLE:**
    - Edge tick → MEASURE, with `cand_valid` <= 0.
  - **MEASURE:**
    - Edge with valid H, `cand_valid` = 1, and code equal to the candidate → LOCKED. `tone_frequency` <= code; `tone_update` pulses.
    - Edge with any other valid H: candidate <= code, `cand_valid` <= 1, stay in MEASURE.
    - Edge with invalid H: `cand_valid` <= 0, stay in MEASURE.
  - **LOCKED:**
    - Edge with H equal to the locked code's half-period: stay in LOCKED, no pulse.
    - Edge with a different valid H → MEASURE, candidate <= new code, `cand_valid` <= 1.
    - Edge with invalid H → MEASURE, `cand_valid` <= 0.
- **Timeout:** from MEASURE or LOCKED, a non-edge tick with `cnt` = `TIMEOUT_TICKS` − 1 → IDLE.
- **Edge vs. timeout:** an edge tick always takes priority. An edge arriving when `cnt` = `TIMEOUT_TICKS` − 1 is processed as an edge, with H = `TIMEOUT_TICKS` (invalid).
- **Output rules:**
  - `tone_active` = 1 exactly while in LOCKED.
  - `tone_frequency` holds its value through MEASURE and IDLE; it changes only on entry into LOCKED.
- **Generator disable:** when the generator is disabled it forces its output low. The decoder sees at most one edge, typically with an invalid H, and then times out to IDLE.

## Timing
- **Reset values:** state = IDLE, `sample` = 0, `cnt` = 0, `cand_valid` = 0, candidate = 0, `tone_active` = 0, `tone_frequency` = 0, `tone_update` = 0.
- **Reset behaviour:** all state clears asynchronously on `reset` = 0, including mid-lock, and releases to IDLE.
- **Registered outputs:** all outputs are registered. They change on the same `clk` edge that processes the qualifying tick.
- **Lock latency:** a steady tone locks on the third observed edge, i.e. 2H ticks after the first edge.
- **`tone_update`:** high for exactly one `clk` cycle on that edge. It is 0 on all non-`clk_en` cycles.
- **Drop on timeout:** `tone_active` falls `TIMEOUT_TICKS` ticks after the last edge.
- **Drop on changed H:** `tone_active` falls on the first edge whose H differs from the locked half-period.
- **Relock after a frequency change:** takes two further edges of the new half-period.
- **Ticks are required:** `buzzer_in` changes between ticks are sampled only at the next tick. With `clk_en` held low, nothing changes.

## Test plan
1. Hold `reset` = 0 while toggling `buzzer_in` and pulsing `clk_en`. Release and leave `buzzer_in` constant → all outputs 0; state stays IDLE.
2. Drive a wave toggling every 4 ticks → `tone_active` = 1 and `tone_frequency` = 0 on the third edge; exactly one `tone_update` pulse over 100 ticks.
3. Sweep codes 0..7 using half-periods 4, 5, 6, 7, 8, 10, 12, 14, with a 30-tick quiet gap between codes → each code locks on its third edge and reports the correct value; `tone_active` = 0 during each gap after 15 ticks.
4. Lock on code 2 (H = 6), then switch to H = 10 → `tone_active` drops on the first 10-tick edge; the next 10-tick edge gives `tone_frequency` = 5, `tone_active` = 1 and one `tone_update` pulse.
5. Lock on code 7, then stop toggling → `tone_active` = 0 exactly 15 ticks after the last edge; `tone_frequency` stays 7. Repeat with an edge at `cnt` = 14 (H = 15) → MEASURE, no lock.
6. Drive a steady H = 9 wave → never locks. Separately, while locked on code 4, assert `reset` = 0 between ticks → outputs clear immediately, without waiting for a `clk` edge.
